// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - pixel-domain raster position and TMDS period sequencer
//
// Owns the x/y raster counters and decides, per pixel, which TMDS period the
// channel encoders emit: control, video preamble, video guard band or video.
// All outputs are registered from the same next position, so they never skew
// against x/y.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous reset, active-high
//   enable      in   advance the raster when high, hold every register when low
//   x, y        out  current raster position (10 bit)
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync, whole-line aligned
//   period      out  0=CONTROL 1=PREAMBLE 2=GUARD 3=VIDEO
//   ctl         out  CTL3..CTL0 for the channel 2/1 control symbols
//   de          out  high iff period is VIDEO
//   de_next     out  position after the next increment is in the video region
//   line_start  out  pulse at x==0
//   frame_start out  pulse at x==0, y==0
module hdmi_period_scheduler #(
  parameter int FRAME_WIDTH       = 800,
  parameter int FRAME_HEIGHT      = 525,
  parameter int SCREEN_WIDTH      = 640,
  parameter int SCREEN_HEIGHT     = 480,
  parameter int HSYNC_PULSE_START = 16,
  parameter int HSYNC_PULSE_SIZE  = 96,
  parameter int VSYNC_PULSE_START = 10,
  parameter int VSYNC_PULSE_SIZE  = 2,
  parameter int PREAMBLE_LEN      = 8,
  parameter int GUARD_LEN         = 2,
  parameter int HDMI_MODE         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] period,
  output logic [3:0] ctl,
  output logic       de,
  output logic       de_next,
  output logic       line_start,
  output logic       frame_start
);

  typedef enum logic [1:0] {
    P_CONTROL  = 2'd0,
    P_PREAMBLE = 2'd1,
    P_GUARD    = 2'd2,
    P_VIDEO    = 2'd3
  } period_t;

  localparam logic [9:0] X_LAST  = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0] Y_LAST  = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] SW      = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SH      = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] SH_M1   = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] HS_BEG  = 10'(SCREEN_WIDTH + HSYNC_PULSE_START);
  localparam logic [9:0] HS_END  = 10'(SCREEN_WIDTH + HSYNC_PULSE_START + HSYNC_PULSE_SIZE);
  localparam logic [9:0] VS_BEG  = 10'(SCREEN_HEIGHT + VSYNC_PULSE_START);
  localparam logic [9:0] VS_END  = 10'(SCREEN_HEIGHT + VSYNC_PULSE_START + VSYNC_PULSE_SIZE);
  localparam logic [9:0] PRE_BEG = 10'(FRAME_WIDTH - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [9:0] GRD_BEG = 10'(FRAME_WIDTH - GUARD_LEN);

  // The preamble/guard window must sit entirely after the hsync pulse.
  if (FRAME_WIDTH - GUARD_LEN - PREAMBLE_LEN <
      SCREEN_WIDTH + HSYNC_PULSE_START + HSYNC_PULSE_SIZE) begin : g_bad_geometry
    $error("hdmi_period_scheduler: preamble/guard window overlaps horizontal sync");
  end

  function automatic logic [9:0] next_x(input logic [9:0] px);
    return (px == X_LAST) ? 10'd0 : px + 10'd1;
  endfunction

  function automatic logic [9:0] next_y(input logic [9:0] px, input logic [9:0] py);
    if (px != X_LAST) return py;
    return (py == Y_LAST) ? 10'd0 : py + 10'd1;
  endfunction

  function automatic logic in_video(input logic [9:0] px, input logic [9:0] py);
    return (px < SW) && (py < SH);
  endfunction

  // A line leads into video when the line after it is active.
  function automatic logic lead_in_line(input logic [9:0] py);
    return (py < SH_M1) || (py == Y_LAST);
  endfunction

  function automatic period_t raw_period(input logic [9:0] px, input logic [9:0] py);
    if (in_video(px, py)) return P_VIDEO;
    if (HDMI_MODE != 0 && lead_in_line(py)) begin
      if (px >= GRD_BEG) return P_GUARD;
      if (px >= PRE_BEG) return P_PREAMBLE;
    end
    return P_CONTROL;
  endfunction

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  period_t    period_q, period_d;
  logic [3:0] ctl_q, ctl_d;
  logic       de_q, de_d, de_next_q, de_next_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

  logic [9:0] nx, ny, nnx, nny;
  period_t    raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= 10'd0;
      y_q           <= SH;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      period_q      <= P_CONTROL;
      ctl_q         <= 4'd0;
      de_q          <= 1'b0;
      de_next_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      period_q      <= period_d;
      ctl_q         <= ctl_d;
      de_q          <= de_d;
      de_next_q     <= de_next_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    period_d      = period_q;
    ctl_d         = ctl_q;
    de_d          = de_q;
    de_next_d     = de_next_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;

    nx  = next_x(x_q);
    ny  = next_y(x_q, y_q);
    nnx = next_x(nx);
    nny = next_y(nx, ny);
    raw = raw_period(nx, ny);

    if (enable) begin
      x_d      = nx;
      y_d      = ny;
      period_d = raw;
      // In HDMI mode video may only follow a guard band (or continue video);
      // a line that cannot start cleanly stays in control.
      if (HDMI_MODE != 0 && raw == P_VIDEO &&
          period_q != P_GUARD && period_q != P_VIDEO) begin
        period_d = P_CONTROL;
      end
      hsync_d       = !((nx >= HS_BEG) && (nx < HS_END));
      vsync_d       = !((ny >= VS_BEG) && (ny < VS_END));
      ctl_d         = (period_d == P_PREAMBLE) ? 4'b0001 : 4'b0000;
      de_d          = (period_d == P_VIDEO);
      de_next_d     = in_video(nnx, nny);
      line_start_d  = (nx == 10'd0);
      frame_start_d = (nx == 10'd0) && (ny == 10'd0);
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign period      = period_q;
  assign ctl         = ctl_q;
  assign de          = de_q;
  assign de_next     = de_next_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - directed bench for hdmi_period_scheduler
module tb_hdmi_period_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // a: default 640x480 geometry; b: small HDMI geometry; c: small DVI geometry
  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hs_a, vs_a, de_a, dn_a, ls_a, fs_a;
  logic hs_b, vs_b, de_b, dn_b, ls_b, fs_b;
  logic hs_c, vs_c, de_c, dn_c, ls_c, fs_c;
  logic [1:0] per_a, per_b, per_c;
  logic [3:0] ctl_a, ctl_b, ctl_c;

  hdmi_period_scheduler dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
    .period(per_a), .ctl(ctl_a), .de(de_a), .de_next(dn_a), .line_start(ls_a), .frame_start(fs_a)
  );

  hdmi_period_scheduler #(
    .FRAME_WIDTH(40), .FRAME_HEIGHT(20), .SCREEN_WIDTH(16), .SCREEN_HEIGHT(12),
    .HSYNC_PULSE_START(2), .HSYNC_PULSE_SIZE(4), .VSYNC_PULSE_START(2), .VSYNC_PULSE_SIZE(2),
    .PREAMBLE_LEN(8), .GUARD_LEN(2), .HDMI_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
    .period(per_b), .ctl(ctl_b), .de(de_b), .de_next(dn_b), .line_start(ls_b), .frame_start(fs_b)
  );

  hdmi_period_scheduler #(
    .FRAME_WIDTH(40), .FRAME_HEIGHT(20), .SCREEN_WIDTH(16), .SCREEN_HEIGHT(12),
    .HSYNC_PULSE_START(2), .HSYNC_PULSE_SIZE(4), .VSYNC_PULSE_START(2), .VSYNC_PULSE_SIZE(2),
    .PREAMBLE_LEN(8), .GUARD_LEN(2), .HDMI_MODE(0)
  ) dut_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .x(x_c), .y(y_c), .hsync(hs_c), .vsync(vs_c),
    .period(per_c), .ctl(ctl_c), .de(de_c), .de_next(dn_c), .line_start(ls_c), .frame_start(fs_c)
  );

  function automatic logic [31:0] snap_b();
    return {x_b, y_b, hs_b, vs_b, per_b, ctl_b, de_b, dn_b, ls_b, fs_b};
  endfunction

  initial begin
    int e_pos, e_per, e_ctl, e_de, e_dn, e_hs, e_vs, e_pulse;
    int c_pre, c_grd, c_vid, c_fs, c_vslo, c_l11;
    int l10_vid, hs_first, hs_last, dn_799, dn_639, per_00, fs_00;
    int yy, nx, ny, ep, pre_cnt, grd_cnt, first_pre_y, steps;
    logic vid, lead, first, edn, els, efs, ehs, evs, frozen;
    logic [31:0] snap;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    rst_c = 1'b1; en_c = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_x", 32'(x_a), 0);
    check("rst_y", 32'(y_a), 480);
    check("rst_hsync", 32'(hs_a), 1);
    check("rst_vsync", 32'(vs_a), 1);
    check("rst_period", 32'(per_a), 0);
    check("rst_ctl", 32'(ctl_a), 0);
    check("rst_de", 32'(de_a), 0);
    check("rst_de_next", 32'(dn_a), 0);
    check("rst_line_start", 32'(ls_a), 0);
    check("rst_frame_start", 32'(fs_a), 0);
    check("rst_small_y", 32'(y_b), 12);

    // ---- default geometry: y=480..524 then y=0..10 ----
    rst_a = 1'b0;
    e_pos = 0; e_per = 0; e_ctl = 0; e_de = 0; e_dn = 0; e_hs = 0; e_vs = 0; e_pulse = 0;
    c_pre = 0; c_grd = 0; c_vid = 0; c_fs = 0; c_vslo = 0;
    l10_vid = 0; hs_first = -1; hs_last = -1; dn_799 = -1; dn_639 = -1; per_00 = -1; fs_00 = -1;
    for (int li = 0; li < 56; li++) begin
      yy = (li < 45) ? 480 + li : li - 45;
      for (int xx = 0; xx < 800; xx++) begin
        first = (li == 0) && (xx == 0);
        vid   = (xx < 640) && (yy < 480);
        lead  = (yy < 479) || (yy == 524);
        ep    = vid ? 3 : (lead && xx >= 798) ? 2 : (lead && xx >= 790) ? 1 : 0;
        nx    = (xx == 799) ? 0 : xx + 1;
        ny    = (xx == 799) ? ((yy == 524) ? 0 : yy + 1) : yy;
        edn   = (nx < 640) && (ny < 480);
        els   = (xx == 0) && !first;
        efs   = (xx == 0) && (yy == 0);
        ehs   = !(xx >= 656 && xx < 752);
        evs   = !(yy == 490 || yy == 491);
        if (int'(x_a) != xx || int'(y_a) != yy) e_pos++;
        if (int'(per_a) != ep) e_per++;
        if (ctl_a !== ((ep == 1) ? 4'b0001 : 4'b0000)) e_ctl++;
        if (de_a !== (ep == 3)) e_de++;
        if (dn_a !== edn) e_dn++;
        if (hs_a !== ehs) e_hs++;
        if (vs_a !== evs) e_vs++;
        if (ls_a !== els || fs_a !== efs) e_pulse++;
        if (per_a == 2'd1) c_pre++;
        if (per_a == 2'd2) c_grd++;
        if (per_a == 2'd3) c_vid++;
        if (fs_a) c_fs++;
        if (!vs_a) c_vslo++;
        if (yy == 9 && xx == 799) dn_799 = int'(dn_a);
        if (yy == 0 && xx == 0) begin per_00 = int'(per_a); fs_00 = int'(fs_a); end
        if (yy == 10) begin
          if (per_a == 2'd3) l10_vid++;
          if (xx == 639) dn_639 = int'(dn_a);
          if (!hs_a) begin
            if (hs_first < 0) hs_first = xx;
            hs_last = xx;
          end
        end
        @(negedge clk);
      end
    end
    check("a_position", 32'(e_pos), 0);
    check("a_period", 32'(e_per), 0);
    check("a_ctl", 32'(e_ctl), 0);
    check("a_de", 32'(e_de), 0);
    check("a_de_next", 32'(e_dn), 0);
    check("a_hsync", 32'(e_hs), 0);
    check("a_vsync", 32'(e_vs), 0);
    check("a_pulses", 32'(e_pulse), 0);
    check("a_preamble_cycles", 32'(c_pre), 96);
    check("a_guard_cycles", 32'(c_grd), 24);
    check("a_video_cycles", 32'(c_vid), 7040);
    check("a_frame_starts", 32'(c_fs), 1);
    check("a_vsync_low_cycles", 32'(c_vslo), 1600);
    check("a_period_at_0_0", 32'(per_00), 3);
    check("a_frame_start_at_0_0", 32'(fs_00), 1);
    check("a_de_next_x799", 32'(dn_799), 1);
    check("a_de_next_x639", 32'(dn_639), 0);
    check("a_line10_video", 32'(l10_vid), 640);
    check("a_hsync_first", 32'(hs_first), 656);
    check("a_hsync_last", 32'(hs_last), 751);

    // ---- small HDMI geometry: one full frame from reset ----
    rst_b = 1'b0;
    e_pos = 0; e_per = 0; e_de = 0; e_hs = 0; e_vs = 0;
    c_pre = 0; c_grd = 0; c_vid = 0; c_vslo = 0; c_l11 = 0;
    for (int li = 0; li < 20; li++) begin
      yy = (li < 8) ? 12 + li : li - 8;
      for (int xx = 0; xx < 40; xx++) begin
        vid  = (xx < 16) && (yy < 12);
        lead = (yy < 11) || (yy == 19);
        ep   = vid ? 3 : (lead && xx >= 38) ? 2 : (lead && xx >= 30) ? 1 : 0;
        if (int'(x_b) != xx || int'(y_b) != yy) e_pos++;
        if (int'(per_b) != ep) e_per++;
        if (de_b !== (per_b == 2'd3)) e_de++;
        if (hs_b !== !(xx >= 18 && xx < 22)) e_hs++;
        if (vs_b !== !(yy == 14 || yy == 15)) e_vs++;
        if (per_b == 2'd1) c_pre++;
        if (per_b == 2'd2) c_grd++;
        if (per_b == 2'd3) c_vid++;
        if (!vs_b) c_vslo++;
        if (yy == 11 && (per_b == 2'd1 || per_b == 2'd2)) c_l11++;
        @(negedge clk);
      end
    end
    check("b_position", 32'(e_pos), 0);
    check("b_period", 32'(e_per), 0);
    check("b_de", 32'(e_de), 0);
    check("b_hsync", 32'(e_hs), 0);
    check("b_vsync", 32'(e_vs), 0);
    check("b_preamble_cycles", 32'(c_pre), 96);
    check("b_guard_cycles", 32'(c_grd), 24);
    check("b_video_cycles", 32'(c_vid), 192);
    check("b_vsync_low_cycles", 32'(c_vslo), 80);
    check("b_last_active_line_lead", 32'(c_l11), 0);

    // ---- enable held low in the middle of the preamble ----
    repeat (7 * 40 + 30) @(negedge clk);
    check("b_pre_start_x", 32'(x_b), 30);
    check("b_pre_start_y", 32'(y_b), 19);
    pre_cnt = 0; grd_cnt = 0; frozen = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if (per_b == 2'd1) pre_cnt++;
      if (per_b == 2'd2) grd_cnt++;
      if (x_b == 10'd35 && !frozen) begin
        frozen = 1'b1;
        snap = snap_b();
        en_b = 1'b0;
        repeat (5) @(negedge clk);
        check("b_freeze_all", snap_b(), snap);
        check("b_freeze_ctl", 32'(ctl_b), 1);
        en_b = 1'b1;
      end
      @(negedge clk);
    end
    check("b_freeze_seen", 32'(frozen), 1);
    check("b_preamble_total", 32'(pre_cnt), 8);
    check("b_guard_total", 32'(grd_cnt), 2);
    check("b_video_after_guard", 32'(per_b), 3);
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("b_held_line_start", 32'(ls_b), 1);
    check("b_held_frame_start", 32'(fs_b), 1);
    check("b_held_x", 32'(x_b), 0);
    en_b = 1'b1;

    // ---- asynchronous reset during the guard band ----
    repeat (5 * 40 + 39) @(negedge clk);
    check("b_pre_reset_period", 32'(per_b), 2);
    check("b_pre_reset_y", 32'(y_b), 5);
    rst_b = 1'b1;
    #1;
    check("b_async_x", 32'(x_b), 0);
    check("b_async_y", 32'(y_b), 12);
    check("b_async_period", 32'(per_b), 0);
    @(negedge clk);
    rst_b = 1'b0;
    pre_cnt = 0; grd_cnt = 0; first_pre_y = -1; steps = 0;
    while (per_b != 2'd3 && steps < 1000) begin
      if (per_b == 2'd1) begin
        pre_cnt++;
        if (first_pre_y < 0) first_pre_y = int'(y_b);
      end
      if (per_b == 2'd2) grd_cnt++;
      steps++;
      @(negedge clk);
    end
    check("b_reset_video_reached", 32'(steps < 1000), 1);
    check("b_reset_preamble", 32'(pre_cnt), 8);
    check("b_reset_guard", 32'(grd_cnt), 2);
    check("b_reset_preamble_line", 32'(first_pre_y), 19);
    check("b_reset_video_pos", {22'd0, x_b} | 32'(y_b), 0);

    // ---- DVI mode: one full frame ----
    rst_c = 1'b0;
    c_pre = 0; c_vid = 0; e_ctl = 0; e_de = 0;
    for (int i = 0; i < 800; i++) begin
      if (per_c == 2'd1 || per_c == 2'd2) c_pre++;
      if (per_c == 2'd3) c_vid++;
      if (ctl_c != 4'd0) e_ctl++;
      if (de_c !== (per_c == 2'd3)) e_de++;
      @(negedge clk);
    end
    check("c_no_preamble_guard", 32'(c_pre), 0);
    check("c_video_cycles", 32'(c_vid), 192);
    check("c_ctl_zero", 32'(e_ctl), 0);
    check("c_de", 32'(e_de), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Pixel-clock-domain sequencer that owns raster position and decides, per pixel, which TMDS period the three channel encoders/serialisers emit: control, video preamble, video guard band or active video.
- Replaces the inline x/y counters, sync and data-enable logic in the top level.
- Drives the per-channel mux in front of the OSER10 serialisers and the CTL bits for the control-symbol encoder.
- HDMI_MODE=0 degrades to plain DVI: no preamble, no guard band.

Parameters:
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines
- HSYNC_PULSE_START, 16, pixels after active region before hsync
- HSYNC_PULSE_SIZE, 96, hsync width in pixels
- VSYNC_PULSE_START, 10, lines after active region before vsync
- VSYNC_PULSE_SIZE, 2, vsync width in lines
- PREAMBLE_LEN, 8, video preamble length in pixels
- GUARD_LEN, 2, video guard band length in pixels
- HDMI_MODE, 1, 1 = emit preamble/guard; 0 = DVI

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  advance raster when high; hold all state when low
- x  out  10  current horizontal position
- y  out  10  current vertical position
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- period  out  2  0=CONTROL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
- ctl  out  4  CTL3..CTL0 for channels 2/1 control symbols
- de  out  1  high iff period==VIDEO
- de_next  out  1  high when the next enabled cycle will be VIDEO (pixel fetch request)
- line_start  out  1  one-cycle pulse at x==0
- frame_start  out  1  one-cycle pulse at x==0, y==0

Behaviour:
- All outputs are registered and describe the same position (x,y). There is no skew between x/y and the other outputs.
- Reset (async) drives position to (0, SCREEN_HEIGHT), the start of vertical blanking, so the first frame out of reset is clean:
  - x=0, y=480, hsync=1, vsync=1, period=CONTROL, ctl=0, de=0, de_next=0, line_start=0, frame_start=0.
- Each clk edge with enable=1:
  - x increments.
  - At x==FRAME_WIDTH-1, x wraps to 0 and y increments.
  - At y==FRAME_HEIGHT-1, y wraps to 0.
  - All outputs are recomputed from the new position.
- enable=0: every register holds, including pulses (a held pulse stays high).
- Video region: x<SCREEN_WIDTH and y<SCREEN_HEIGHT.
- hsync low iff SCREEN_WIDTH+HSYNC_PULSE_START <= x < that + HSYNC_PULSE_SIZE.
- vsync low iff SCREEN_HEIGHT+VSYNC_PULSE_START <= y < that + VSYNC_PULSE_SIZE. Transitions are whole-line aligned (at x==0).
- Period FSM (CONTROL -> PREAMBLE -> GUARD -> VIDEO -> CONTROL), HDMI_MODE=1:
  - Applies on any line whose successor line is active, i.e. y<SCREEN_HEIGHT-1 or y==FRAME_HEIGHT-1.
  - PREAMBLE for x in [FRAME_WIDTH-GUARD_LEN-PREAMBLE_LEN, FRAME_WIDTH-GUARD_LEN-1].
  - GUARD for x in [FRAME_WIDTH-GUARD_LEN, FRAME_WIDTH-1].
  - VIDEO in the video region; CONTROL everywhere else.
  - VIDEO is entered only from GUARD. CONTROL never goes directly to VIDEO.
- HDMI_MODE=0: period only ever CONTROL or VIDEO; ctl is always 0.
- ctl = 4'b0001 (CTL0=1) during PREAMBLE; 0 otherwise.
- de_next is high when the position after the next increment lies in the video region.
- Widths: counters are 10 bit. Parameters must satisfy FRAME_WIDTH-GUARD_LEN-PREAMBLE_LEN >= SCREEN_WIDTH+HSYNC_PULSE_START+HSYNC_PULSE_SIZE; elaboration error otherwise.
- Reset mid-line or mid-preamble: immediate return to reset values. No partial guard band or video is ever emitted after reset release.

Test Plan:
- Release reset, enable=1 -> first 45 lines (y=480..524) period=CONTROL except y=524 x=790..797 PREAMBLE (ctl=0001) and x=798..799 GUARD. Next cycle x=0, y=0: period=VIDEO, de=1, frame_start=1.
- Run one full line y=10 -> VIDEO at x=0..639, CONTROL at 640..789, PREAMBLE at 790..797, GUARD at 798..799. de_next=1 at x=799 and x=0..638, 0 at 639. hsync low exactly x=656..751.
- Line y=479 -> no PREAMBLE/GUARD at x=790..799. y=480 all CONTROL. vsync low exactly on y=490 and 491, all x.
- HDMI_MODE=0, full frame -> period never 1 or 2, ctl always 0, 307200 VIDEO cycles per frame.
- Toggle enable low for 5 cycles at x=795 (PREAMBLE) -> all outputs frozen. On re-enable, sequence continues at x=796 with preamble totalling exactly 8 enabled cycles.
- Assert rst at x=799 (GUARD), y=100 -> outputs asynchronously become x=0, y=480, period=CONTROL. After release, the next VIDEO is preceded by a full 8+2 preamble/guard at y=524.
